// File: rtl/bcd_xs3_pkg.sv
// Shared definitions for the BCD to excess-3 digit-serial converter:
// FSM state encoding, BCD digit limit and a digit validity helper.
package bcd_xs3_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StConv = ST_CONV,
    StDone = ST_DONE
  } state_e;

  localparam logic [3:0] XS3_BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= XS3_BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_to_excess_3.sv
// Gate-level single-digit BCD to excess-3 cell. Defined for all 16 input codes;
// codes 0..9 map to code+3, codes 10..15 produce whatever the gates give.
module bcd_to_excess_3 (
  input  logic [3:0] bcd_i,
  output logic [3:0] xs3_o
);

  logic lo_any;

  assign lo_any   = bcd_i[0] | bcd_i[1];
  assign xs3_o[0] = ~bcd_i[0];
  assign xs3_o[1] = ~(bcd_i[0] ^ bcd_i[1]);
  assign xs3_o[2] = bcd_i[2] ^ lo_any;
  assign xs3_o[3] = bcd_i[3] | (bcd_i[2] & lo_any);

endmodule

// File: rtl/bcd_xs3_seq_converter.sv
// Converts a packed multi-digit BCD word to excess-3 one digit per clock through a
// single shared converter cell, with valid/ready handshakes on input and output.
module bcd_xs3_seq_converter
  import bcd_xs3_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_xs3,
  output logic                  out_err,
  output logic                  busy
);

  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIGITS - 1);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   cap_q, cap_d;
  logic [4*DIGITS-1:0]   res_q, res_d;
  logic                  err_q, err_d;

  logic [3:0]            cell_in;
  logic [3:0]            cell_out;

  // DIGITS:1 digit select feeding the one shared cell.
  always_comb begin
    cell_in = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (cnt_q == CntW'(i)) cell_in = cap_q[4*i +: 4];
    end
  end

  bcd_to_excess_3 u_cell (
    .bcd_i (cell_in),
    .xs3_o (cell_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          cap_d   = in_bcd;
          res_d   = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (cnt_q == CntW'(i)) res_d[4*i +: 4] = cell_out;
        end
        err_d = err_q | ~is_bcd(cell_in);
        // Counter stops at the last digit instead of wrapping.
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cap_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_xs3   = res_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_bcd_xs3_seq_converter.sv
// Directed bench for bcd_xs3_seq_converter: a transaction-level model checked every
// cycle, plus literal expected results for each directed word.
module tb_bcd_xs3_seq_converter;

  localparam int unsigned DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_bcd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_xs3;
  logic        out_err;
  logic        busy;

  int checks = 0;
  int errs   = 0;

  bcd_xs3_seq_converter #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xs3   (out_xs3),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cell behaviour as arithmetic: digit+3 modulo 16, with the top bit forced for digits >= 8.
  function automatic logic [15:0] xs3_of(input logic [15:0] w);
    logic [15:0] r;
    int d, x;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      d = int'(w[4*i +: 4]);
      x = (d + 3) % 16;
      if (d >= 8) x = x | 8;
      r[4*i +: 4] = 4'(x);
    end
    return r;
  endfunction

  function automatic logic err_of(input logic [15:0] w);
    logic e;
    e = 1'b0;
    for (int i = 0; i < 4; i++) if (int'(w[4*i +: 4]) > 9) e = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: idle, converting for DIGITS cycles, then holding the result.
  typedef enum int {MIdle, MConv, MDone} mph_e;
  mph_e        m_ph = MIdle;
  int          m_left = 0;
  logic [15:0] m_xs3 = '0;
  logic        m_err = 1'b0;
  logic        m_fresh = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph    = MIdle;
      m_left  = 0;
      m_fresh = 1'b1;
    end else begin
      case (m_ph)
        MIdle: if (in_valid) begin
          m_xs3   = xs3_of(in_bcd);
          m_err   = err_of(in_bcd);
          m_left  = DIGITS;
          m_ph    = MConv;
          m_fresh = 1'b0;
        end
        MConv: begin
          m_left--;
          if (m_left == 0) m_ph = MDone;
        end
        MDone: if (out_ready) m_ph = MIdle;
        default: m_ph = MIdle;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", 16'(out_valid), 16'd0);
      check("rst_out_xs3", out_xs3, 16'd0);
      check("rst_out_err", 16'(out_err), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_in_ready", 16'(in_ready), 16'd1);
    end else begin
      check("in_ready", 16'(in_ready), 16'(m_ph == MIdle));
      check("busy", 16'(busy), 16'(m_ph != MIdle));
      check("out_valid", 16'(out_valid), 16'(m_ph == MDone));
      if (m_ph == MDone) begin
        check("out_xs3", out_xs3, m_xs3);
        check("out_err", 16'(out_err), 16'(m_err));
      end
      if (m_fresh) begin
        check("idle_xs3", out_xs3, 16'd0);
        check("idle_err", 16'(out_err), 16'd0);
      end
    end
  end

  // Presents one word for a single cycle; returns #1 after the accepting edge.
  task automatic send(input logic [15:0] w);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_bcd   = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_done(input logic [15:0] exp, input logic e, input int hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errs++;
      $display("FAIL done_timeout: got out_valid=0, expected 1 within 20 cycles");
    end
    check("latency", 16'(n), 16'(DIGITS));
    check("lit_xs3", out_xs3, exp);
    check("lit_err", 16'(out_err), 16'(e));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      in_valid = i[0];
      in_bcd   = 16'hFFFF;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("back_idle", 16'(in_ready), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(16'h1234); expect_done(16'h4567, 1'b0, 0);
    send(16'h0909); expect_done(16'h3C3C, 1'b0, 0);
    send(16'h9999); expect_done(16'hCCCC, 1'b0, 0);
    send(16'h12A4); expect_done(16'h45D7, 1'b1, 0);
    send(16'h0000); expect_done(16'h3333, 1'b0, 0);
    send(16'hFEDB); expect_done(16'hA98E, 1'b1, 0);
    send(16'h0042); expect_done(16'h3375, 1'b0, 5);

    // Reset while the third digit is being converted.
    send(16'h9876);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_valid", 16'(out_valid), 16'd0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'h5678); expect_done(16'h89AB, 1'b0, 0);

    // Reset while a result is being held.
    send(16'h0001);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("done_rst_valid", 16'(out_valid), 16'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'h2468); expect_done(16'h579B, 1'b0, 2);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule
